// File: rtl/spi_ram_if.sv
// Command/response bundle between the SPI slave (master side) and the RAM controller (slave side).
interface spi_ram_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH+1:0] din;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  addr_err;

  modport master (output din, output rx_valid, input dout, input tx_valid, input addr_err);
  modport slave  (input din, input rx_valid, output dout, output tx_valid, output addr_err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port RAM behind the SPI slave: decodes 2-bit opcode commands, keeps separate
// write/read pointers and holds read data valid for a TX_HOLD-cycle window.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH     = 256,
  parameter int ADDR_SIZE     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_AUTO_INC = 0,
  parameter int TX_HOLD       = 8
) (
  input logic      clk,
  input logic      rst_n,
  spi_ram_if.slave bus
);
  localparam int CW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [ADDR_SIZE:0] LP_LAST   = (ADDR_SIZE+1)'(MEM_DEPTH - 1);
  localparam logic [CW-1:0]      LP_RELOAD = CW'(TX_HOLD - 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_tx_valid;
  logic                  r_addr_err;
  logic [ADDR_SIZE-1:0]  r_wr_addr;
  logic [ADDR_SIZE-1:0]  r_rd_addr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [ADDR_SIZE-1:0]  w_addr_in;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_SIZE-1:0]  w_wr_next;
  logic [ADDR_SIZE-1:0]  w_rd_next;
  logic                  w_do_write;

  assign w_op       = bus.din[DATA_WIDTH+1:DATA_WIDTH];
  assign w_payload  = bus.din[DATA_WIDTH-1:0];
  assign w_addr_in  = w_payload[ADDR_SIZE-1:0];
  assign w_wr_ok    = ({1'b0, r_wr_addr} <= LP_LAST);
  assign w_rd_ok    = ({1'b0, r_rd_addr} <= LP_LAST);
  // Out-of-range pointers wrap to 0 just like the last valid address.
  assign w_wr_next  = ({1'b0, r_wr_addr} >= LP_LAST) ? '0 : r_wr_addr + 1'b1;
  assign w_rd_next  = ({1'b0, r_rd_addr} >= LP_LAST) ? '0 : r_rd_addr + 1'b1;
  assign w_do_write = bus.rx_valid && (w_op == OP_WR_DATA) && w_wr_ok;

  assign bus.dout     = r_dout;
  assign bus.tx_valid = r_tx_valid;
  assign bus.addr_err = r_addr_err;

  // RAM array has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
    end else begin
      r_addr_err <= 1'b0;
      if (bus.rx_valid) begin
        case (w_op)
          OP_WR_ADDR: begin
            r_wr_addr  <= w_addr_in;
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
          end
          OP_WR_DATA: begin
            r_addr_err <= !w_wr_ok;
            if (ADDR_AUTO_INC != 0) r_wr_addr <= w_wr_next;
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
          end
          OP_RD_ADDR: begin
            r_rd_addr  <= w_addr_in;
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
          end
          default: begin
            r_dout     <= w_rd_ok ? r_mem[r_rd_addr] : '0;
            r_addr_err <= !w_rd_ok;
            if (ADDR_AUTO_INC != 0) r_rd_addr <= w_rd_next;
            r_state    <= S_HOLD;
            r_cnt      <= LP_RELOAD;
            r_tx_valid <= 1'b1;
          end
        endcase
      end else if (r_state == S_HOLD) begin
        if (r_cnt == '0) begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: three instances (default, auto-increment, MEM_DEPTH=200).
module tb_spi_ram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_if #(.DATA_WIDTH(8)) b0 ();
  spi_ram_if #(.DATA_WIDTH(8)) b1 ();
  spi_ram_if #(.DATA_WIDTH(8)) b2 ();

  spi_ram_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  spi_ram_ctrl #(.ADDR_AUTO_INC(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  spi_ram_ctrl #(.MEM_DEPTH(200)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  logic [7:0] m_mem [3][256];
  int         m_wa [3];
  int         m_ra [3];
  int         depth [3] = '{256, 256, 200};
  bit         ainc [3]  = '{0, 1, 0};
  logic [7:0] q_rd [$];
  bit         q_err [$];

  function automatic logic [7:0] o_dout(input int d);
    case (d)
      0: return b0.dout;
      1: return b1.dout;
      default: return b2.dout;
    endcase
  endfunction
  function automatic logic o_tx(input int d);
    case (d)
      0: return b0.tx_valid;
      1: return b1.tx_valid;
      default: return b2.tx_valid;
    endcase
  endfunction
  function automatic logic o_err(input int d);
    case (d)
      0: return b0.addr_err;
      1: return b1.addr_err;
      default: return b2.addr_err;
    endcase
  endfunction

  task automatic cmd(input int d, input logic [1:0] op, input logic [7:0] p);
    bit ok;
    @(negedge clk);
    case (d)
      0: begin b0.din = {op, p}; b0.rx_valid = 1'b1; end
      1: begin b1.din = {op, p}; b1.rx_valid = 1'b1; end
      default: begin b2.din = {op, p}; b2.rx_valid = 1'b1; end
    endcase
    case (op)
      2'b00: m_wa[d] = int'(p);
      2'b01: begin
        ok = m_wa[d] < depth[d];
        if (ok) m_mem[d][m_wa[d]] = p;
        q_err.push_back(!ok);
        if (ainc[d]) m_wa[d] = (m_wa[d] >= depth[d] - 1) ? 0 : m_wa[d] + 1;
      end
      2'b10: m_ra[d] = int'(p);
      default: begin
        ok = m_ra[d] < depth[d];
        q_rd.push_back(ok ? m_mem[d][m_ra[d]] : 8'h00);
        q_err.push_back(!ok);
        if (ainc[d]) m_ra[d] = (m_ra[d] >= depth[d] - 1) ? 0 : m_ra[d] + 1;
      end
    endcase
    @(posedge clk);
    #1;
    b0.rx_valid = 1'b0;
    b1.rx_valid = 1'b0;
    b2.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin m_wa[d] = 0; m_ra[d] = 0; end
    q_rd.delete();
    q_err.delete();
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_chk++; if (o_dout(d) !== 8'h00) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h need 00", d, o_dout(d)); end
      n_chk++; if (o_tx(d) !== 1'b0) begin n_fail++; $display("FAIL reset_tx[%0d]: got %b need 0", d, o_tx(d)); end
      n_chk++; if (o_err(d) !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b need 0", d, o_err(d)); end
    end
  endtask

  task automatic test_basic_read();
    logic [7:0] e;
    bit ee;
    cmd(0, 2'b00, 8'h2A);
    cmd(0, 2'b01, 8'hC3);
    ee = q_err.pop_front();
    n_chk++; if (b0.addr_err !== ee) begin n_fail++; $display("FAIL basic_wr_err: got %b need %b", b0.addr_err, ee); end
    cmd(0, 2'b10, 8'h2A);
    cmd(0, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b0.dout !== e) begin n_fail++; $display("FAIL basic_dout: got %h need %h", b0.dout, e); end
    n_chk++; if (b0.tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_tx_first: got %b need 1", b0.tx_valid); end
    n_chk++; if (b0.addr_err !== ee) begin n_fail++; $display("FAIL basic_rd_err: got %b need %b", b0.addr_err, ee); end
    for (int i = 1; i < 8; i++) begin
      idle(1);
      n_chk++; if (b0.tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_tx_hold cyc %0d: got %b need 1", i, b0.tx_valid); end
    end
    idle(1);
    n_chk++; if (b0.tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_tx_drop: got %b need 0", b0.tx_valid); end
    idle(2);
    n_chk++; if (b0.dout !== e) begin n_fail++; $display("FAIL basic_dout_keep: got %h need %h", b0.dout, e); end
  endtask

  task automatic test_auto_inc();
    logic [7:0] e;
    bit ee;
    cmd(1, 2'b00, 8'hFF);
    cmd(1, 2'b01, 8'h11);
    cmd(1, 2'b01, 8'h22);
    cmd(1, 2'b01, 8'h33);
    for (int i = 0; i < 3; i++) begin
      ee = q_err.pop_front();
      n_chk++; if (ee !== 1'b0) begin n_fail++; $display("FAIL autoinc_model_err %0d: got %b need 0", i, ee); end
    end
    cmd(1, 2'b10, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      cmd(1, 2'b11, 8'h00);
      e = q_rd.pop_front();
      ee = q_err.pop_front();
      n_chk++; if (b1.dout !== e) begin n_fail++; $display("FAIL autoinc_rd %0d: got %h need %h", i, b1.dout, e); end
      n_chk++; if (b1.addr_err !== ee) begin n_fail++; $display("FAIL autoinc_err %0d: got %b need %b", i, b1.addr_err, ee); end
    end
    idle(9);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    bit ee;
    cmd(1, 2'b00, 8'h40);
    cmd(1, 2'b01, 8'h5A);
    cmd(1, 2'b01, 8'hA5);
    ee = q_err.pop_front();
    ee = q_err.pop_front();
    cmd(1, 2'b10, 8'h40);
    cmd(1, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b1.dout !== e) begin n_fail++; $display("FAIL b2b_first: got %h need %h", b1.dout, e); end
    for (int i = 1; i < 3; i++) begin
      idle(1);
      n_chk++; if (b1.tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_gap %0d: got %b need 1", i, b1.tx_valid); end
    end
    cmd(1, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b1.dout !== e) begin n_fail++; $display("FAIL b2b_second: got %h need %h", b1.dout, e); end
    n_chk++; if (b1.tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_restart: got %b need 1", b1.tx_valid); end
    for (int i = 1; i < 8; i++) begin
      idle(1);
      n_chk++; if (b1.tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_hold %0d: got %b need 1", i, b1.tx_valid); end
    end
    idle(1);
    n_chk++; if (b1.tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tx_drop: got %b need 0", b1.tx_valid); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] e;
    bit ee;
    cmd(2, 2'b00, 8'h05);
    cmd(2, 2'b01, 8'h9C);
    cmd(2, 2'b00, 8'hC7);
    cmd(2, 2'b01, 8'h3C);
    cmd(2, 2'b00, 8'hD0);
    cmd(2, 2'b01, 8'h55);
    for (int i = 0; i < 3; i++) begin
      ee = q_err.pop_front();
      if (i == 2) begin
        n_chk++; if (b2.addr_err !== ee) begin n_fail++; $display("FAIL oor_wr_err: got %b need %b", b2.addr_err, ee); end
      end
    end
    idle(1);
    n_chk++; if (b2.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_wr_pulse: got %b need 0", b2.addr_err); end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      case (k)
        0: a = 8'h05;
        1: a = 8'hD0;
        2: a = 8'hC7;
        default: a = 8'hC8;
      endcase
      cmd(2, 2'b10, a);
      cmd(2, 2'b11, 8'h00);
      e = q_rd.pop_front();
      ee = q_err.pop_front();
      n_chk++; if (b2.dout !== e) begin n_fail++; $display("FAIL oor_dout @%h: got %h need %h", a, b2.dout, e); end
      n_chk++; if (b2.tx_valid !== 1'b1) begin n_fail++; $display("FAIL oor_tx @%h: got %b need 1", a, b2.tx_valid); end
      n_chk++; if (b2.addr_err !== ee) begin n_fail++; $display("FAIL oor_err @%h: got %b need %b", a, b2.addr_err, ee); end
      idle(1);
      n_chk++; if (b2.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse @%h: got %b need 0", a, b2.addr_err); end
    end
    idle(9);
  endtask

  task automatic test_abort();
    logic [7:0] e;
    bit ee;
    cmd(0, 2'b10, 8'h2A);
    cmd(0, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b0.dout !== e) begin n_fail++; $display("FAIL abort_dout: got %h need %h", b0.dout, e); end
    idle(1);
    cmd(0, 2'b00, 8'h50);
    n_chk++; if (b0.tx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_tx: got %b need 0", b0.tx_valid); end
    n_chk++; if (b0.dout !== e) begin n_fail++; $display("FAIL abort_dout_keep: got %h need %h", b0.dout, e); end
    cmd(0, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b0.dout !== e) begin n_fail++; $display("FAIL abort_rd_addr_kept: got %h need %h", b0.dout, e); end
    idle(9);
  endtask

  task automatic test_reset_in_hold();
    logic [7:0] e;
    bit ee;
    cmd(0, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    idle(3);
    n_chk++; if (b0.tx_valid !== 1'b1) begin n_fail++; $display("FAIL rsthold_pre_tx: got %b need 1", b0.tx_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (b0.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_tx: got %b need 0", b0.tx_valid); end
    n_chk++; if (b0.dout !== 8'h00) begin n_fail++; $display("FAIL rsthold_dout: got %h need 00", b0.dout); end
    do_reset();
    cmd(0, 2'b10, 8'h2A);
    cmd(0, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b0.dout !== e) begin n_fail++; $display("FAIL rsthold_mem_kept: got %h need %h", b0.dout, e); end
    cmd(1, 2'b10, 8'hFF);
    cmd(1, 2'b11, 8'h00);
    e = q_rd.pop_front();
    ee = q_err.pop_front();
    n_chk++; if (b1.dout !== e) begin n_fail++; $display("FAIL rsthold_mem_kept_u1: got %h need %h", b1.dout, e); end
    n_chk++; if (q_rd.size() != 0 || q_err.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d left need 0/0", q_rd.size(), q_err.size()); end
    idle(9);
  endtask

  initial begin
    b0.din = '0; b0.rx_valid = 1'b0;
    b1.din = '0; b1.rx_valid = 1'b0;
    b2.din = '0; b2.rx_valid = 1'b0;
    test_reset();
    test_basic_read();
    test_auto_inc();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
